// File: rtl/systolic_pe_pkg.sv
// -----------------------------------------------------------------------------
// tpu_pkg : shared types, constants and fixed-point helpers for systolic_pe.
//   Q      fractional bits of the signed fixed-point format
//   N      operand/result width
//   ACC_W  accumulator width (N plus 8 guard bits)
//   K_MAX  longest dot product a PE will run; CNT_W sizes the pair counter
// No ports (package).
// -----------------------------------------------------------------------------
package tpu_pkg;

  localparam int Q     = 10;
  localparam int N     = 32;
  localparam int ACC_W = N + 8;
  localparam int K_MAX = 256;
  localparam int CNT_W = $clog2(K_MAX + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } pe_state_e;

  typedef logic signed [N-1:0]     fxp_t;
  typedef logic signed [ACC_W-1:0] acc_t;

  typedef struct packed {
    acc_t sum;
    logic clamp;
  } sat_add_t;

  localparam fxp_t FXP_MAX   = {1'b0, {(N-1){1'b1}}};
  localparam fxp_t FXP_MIN   = {1'b1, {(N-1){1'b0}}};
  localparam acc_t FXP_MAX_A = {{(ACC_W-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam acc_t FXP_MIN_A = {{(ACC_W-N+1){1'b1}}, {(N-1){1'b0}}};
  localparam acc_t ACC_MAX   = {1'b0, {(ACC_W-1){1'b1}}};
  localparam acc_t ACC_MIN   = {1'b1, {(ACC_W-1){1'b0}}};

  // Clamp an accumulator value into the N-bit signed result range.
  function automatic fxp_t sat_clip(input acc_t a);
    fxp_t w_r;
    if (a > FXP_MAX_A) begin
      w_r = FXP_MAX;
    end else if (a < FXP_MIN_A) begin
      w_r = FXP_MIN;
    end else begin
      w_r = fxp_t'(a);
    end
    return w_r;
  endfunction

  // Signed add that pins to the accumulator limits instead of wrapping.
  // One extra bit of headroom tells us whether the true sum left the range.
  function automatic sat_add_t acc_sat_add(input acc_t a, input acc_t b);
    logic [ACC_W:0] w_wide;
    sat_add_t       w_r;
    w_wide = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (w_wide[ACC_W] != w_wide[ACC_W-1]) begin
      w_r.clamp = 1'b1;
      w_r.sum   = w_wide[ACC_W] ? ACC_MIN : ACC_MAX;
    end else begin
      w_r.clamp = 1'b0;
      w_r.sum   = acc_t'(w_wide[ACC_W-1:0]);
    end
    return w_r;
  endfunction

endpackage

// File: rtl/systolic_pe_if.sv
// -----------------------------------------------------------------------------
// systolic_pe_if : result drain port of a processing element.
//   res_data   dot-product result (PE -> consumer)
//   res_valid  result available   (PE -> consumer)
//   res_ready  consumer accepts   (consumer -> PE)
// master = PE side, slave = array controller side.
// -----------------------------------------------------------------------------
interface systolic_pe_if;
  import tpu_pkg::*;

  fxp_t res_data;
  logic res_valid;
  logic res_ready;

  modport master (output res_data, output res_valid, input res_ready);
  modport slave  (input res_data, input res_valid, output res_ready);
endinterface

// File: rtl/systolic_pe_fxp_mul.sv
// -----------------------------------------------------------------------------
// fxp_mul : combinational signed fixed-point multiply.
//   i_a, i_b  N-bit signed operands
//   o_p       full 2N-bit product shifted right by Q (floor), resized to OUT_W
// -----------------------------------------------------------------------------
module fxp_mul #(
  parameter int Q     = 10,
  parameter int N     = 32,
  parameter int OUT_W = 2 * N
) (
  input  logic signed [N-1:0]     i_a,
  input  logic signed [N-1:0]     i_b,
  output logic signed [OUT_W-1:0] o_p
);

  logic signed [2*N-1:0] w_a_ext;
  logic signed [2*N-1:0] w_b_ext;
  logic signed [2*N-1:0] w_full;

  // Widen first so the product is formed at full precision.
  assign w_a_ext = {{N{i_a[N-1]}}, i_a};
  assign w_b_ext = {{N{i_b[N-1]}}, i_b};
  assign w_full  = w_a_ext * w_b_ext;
  // Arithmetic shift gives floor rounding for negative products.
  assign o_p     = OUT_W'(w_full >>> Q);

endmodule

// File: rtl/systolic_pe.sv
// -----------------------------------------------------------------------------
// systolic_pe : output-stationary fixed-point MAC cell of a systolic array.
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_en                    global advance; low freezes every register
//   i_start, i_k_len        begin a dot product of i_k_len pairs (IDLE only)
//   i_x_in/i_x_vld_in       west operand  -> o_x_out/o_x_vld_out (1 cycle)
//   i_y_in/i_y_vld_in       north operand -> o_y_out/o_y_vld_out (1 cycle)
//   o_busy                  state is not IDLE
//   o_sat_flag              sticky clamp indicator for the current product
//   res (master)            result valid/ready port
// Build option SYSTOLIC_PE_SAT_EN: saturating accumulate and result clamp.
// Without it the accumulator wraps and the result is its low N bits.
// -----------------------------------------------------------------------------
module systolic_pe
  import tpu_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_k_len,
  input  fxp_t             i_x_in,
  input  logic             i_x_vld_in,
  input  fxp_t             i_y_in,
  input  logic             i_y_vld_in,
  output fxp_t             o_x_out,
  output logic             o_x_vld_out,
  output fxp_t             o_y_out,
  output logic             o_y_vld_out,
  output logic             o_busy,
  output logic             o_sat_flag,
  systolic_pe_if.master    res
);

  localparam logic [CNT_W-1:0] K_MAX_C = CNT_W'(K_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  pe_state_e        r_state;
  pe_state_e        w_state_nxt;
  acc_t             r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_k_lat;
  fxp_t             r_x_out;
  fxp_t             r_y_out;
  logic             r_x_vld;
  logic             r_y_vld;
  logic             r_busy;
  fxp_t             r_res_data;
  logic             r_res_valid;
  logic             r_sat;

  acc_t             w_p;
  acc_t             w_acc_nxt;
  fxp_t             w_res_nxt;
  logic             w_add_clamp;
  logic             w_res_clamp;
  logic             w_accept;
  logic             w_last;
  logic             w_handshake;
  logic             w_go_accum;
  logic             w_go_zero;
  logic [CNT_W-1:0] w_k_clamp;
  logic [CNT_W-1:0] w_cnt_inc;

  fxp_mul #(.Q(Q), .N(N), .OUT_W(ACC_W)) u_mul (
    .i_a (i_x_in),
    .i_b (i_y_in),
    .o_p (w_p)
  );

  assign w_accept    = i_en && i_x_vld_in && i_y_vld_in && (r_state == ACCUM);
  assign w_cnt_inc   = r_cnt + CNT_ONE;
  assign w_last      = w_accept && (w_cnt_inc == r_k_lat);
  assign w_handshake = i_en && r_res_valid && res.res_ready && (r_state == DONE);
  assign w_k_clamp   = (i_k_len > K_MAX_C) ? K_MAX_C : i_k_len;

  // Accumulate step and result reduction for the operand pair on the inputs.
  always_comb begin
    w_acc_nxt   = r_acc;
    w_res_nxt   = r_res_data;
    w_add_clamp = 1'b0;
    w_res_clamp = 1'b0;
`ifdef SYSTOLIC_PE_SAT_EN
    begin
      sat_add_t w_sa;
      w_sa        = acc_sat_add(r_acc, w_p);
      w_acc_nxt   = w_sa.sum;
      w_add_clamp = w_sa.clamp;
      w_res_nxt   = sat_clip(w_acc_nxt);
      w_res_clamp = (acc_t'(w_res_nxt) != w_acc_nxt);
    end
`else
    w_acc_nxt = r_acc + w_p;
    w_res_nxt = fxp_t'(w_acc_nxt);
`endif
  end

  // Next-state logic; start is only looked at while IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_go_accum  = 1'b0;
    w_go_zero   = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_en && i_start) begin
          if (i_k_len == CNT_ZERO) begin
            w_state_nxt = DONE;
            w_go_zero   = 1'b1;
          end else begin
            w_state_nxt = ACCUM;
            w_go_accum  = 1'b1;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ACCUM: begin
        if (w_last) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = ACCUM;
        end
      end
      DONE: begin
        if (w_handshake) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = DONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else if (i_en) begin
      r_state <= w_state_nxt;
    end
  end

  // Operand forwarding, accumulator, counter and result registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_x_out     <= '0;
      r_y_out     <= '0;
      r_x_vld     <= 1'b0;
      r_y_vld     <= 1'b0;
      r_busy      <= 1'b0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_k_lat     <= '0;
      r_res_data  <= '0;
      r_res_valid <= 1'b0;
      r_sat       <= 1'b0;
    end else if (i_en) begin
      r_x_out <= i_x_in;
      r_y_out <= i_y_in;
      r_x_vld <= i_x_vld_in;
      r_y_vld <= i_y_vld_in;
      r_busy  <= (w_state_nxt != IDLE);
      if (w_go_accum) begin
        r_acc   <= '0;
        r_cnt   <= '0;
        r_sat   <= 1'b0;
        r_k_lat <= w_k_clamp;
      end else if (w_go_zero) begin
        // Zero-length product: result is ready immediately and equals 0.
        r_acc       <= '0;
        r_cnt       <= '0;
        r_sat       <= 1'b0;
        r_k_lat     <= '0;
        r_res_data  <= '0;
        r_res_valid <= 1'b1;
      end else if (w_accept) begin
        r_acc <= w_acc_nxt;
        r_cnt <= w_cnt_inc;
        // The result clamp only matters for the value actually published.
        r_sat <= r_sat | w_add_clamp | (w_last & w_res_clamp);
        if (w_last) begin
          r_res_data  <= w_res_nxt;
          r_res_valid <= 1'b1;
        end
      end else if (w_handshake) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign o_x_out       = r_x_out;
  assign o_y_out       = r_y_out;
  assign o_x_vld_out   = r_x_vld;
  assign o_y_vld_out   = r_y_vld;
  assign o_busy        = r_busy;
  assign o_sat_flag    = r_sat;
  assign res.res_data  = r_res_data;
  assign res.res_valid = r_res_valid;

endmodule
